// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Last stage of the core pipeline, sitting directly in front of the register
// file. ALU/CSR results are written back one cycle after they are accepted.
// Loads park the stage in WAIT_MEM until the data memory answers. The returned
// word is then sliced, aligned and sign/zero-extended, and written one cycle
// after the response.
//
// Optional build macro: WB_RETIRE_CNT_EN adds a 64-bit retired-instruction
// counter on instret_o.
//
// Ports
//   clk_i         system clock
//   rstn_i        asynchronous active-low reset
//   valid_i       execute presents an instruction
//   ready_o       stage can accept (high in IDLE only)
//   rd_i          destination register
//   exe_data_i    result for non-load instructions
//   is_load_i     instruction is a load
//   funct3_i      RISC-V load funct3
//   addr_lsb_i    low bits of the load byte address
//   mem_rvalid_i  data memory read response valid
//   mem_rdata_i   data memory read word (naturally aligned)
//   wb_valid_o    register-file write enable (one-cycle pulse)
//   rd_o          register-file write address
//   rd_data_o     register-file write data
//   instret_o     retired-instruction count (WB_RETIRE_CNT_EN only)
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [RF_ADDR_WIDTH-1:0] rd_i,
  input  logic [DATA_WIDTH-1:0]    exe_data_i,
  input  logic                     is_load_i,
  input  logic [2:0]               funct3_i,
  input  logic [2:0]               addr_lsb_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  output logic                     wb_valid_o,
  output logic [RF_ADDR_WIDTH-1:0] rd_o,
  output logic [DATA_WIDTH-1:0]    rd_data_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]              instret_o
`endif
);

  // Byte-offset width inside one memory word: 2 bits for RV32, 3 for RV64.
  localparam int OFF_W = (DATA_WIDTH == 64) ? 3 : 2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t                   state_reg, state_next;
  logic [RF_ADDR_WIDTH-1:0] pend_rd_reg, pend_rd_next;
  logic [2:0]               pend_funct3_reg, pend_funct3_next;
  logic [2:0]               pend_lsb_reg, pend_lsb_next;
  logic                     wb_valid_next;
  logic [RF_ADDR_WIDTH-1:0] rd_next;
  logic [DATA_WIDTH-1:0]    rd_data_next;

  logic                     accept;
  logic [OFF_W-1:0]         off_b, off_h, off_w;
  logic [7:0]               byte_val;
  logic [15:0]              half_val;
  logic [31:0]              word_val;
  logic [DATA_WIDTH-1:0]    load_data;
  logic                     unused_lsb;

  assign ready_o = (state_reg == IDLE);
  assign accept  = valid_i && ready_o;

  // Only the offset bits that address a byte inside the word matter; the
  // upper lsb bit is meaningless on RV32.
  assign unused_lsb = ^pend_lsb_reg;
  assign off_b      = pend_lsb_reg[OFF_W-1:0];
  // Sub-word alignment bits are dropped, not checked.
  assign off_h      = off_b & ~OFF_W'(1);
  assign off_w      = off_b & ~OFF_W'(3);

  assign byte_val = 8'(mem_rdata_i >> {off_b, 3'b000});
  assign half_val = 16'(mem_rdata_i >> {off_h, 3'b000});
  assign word_val = 32'(mem_rdata_i >> {off_w, 3'b000});

  always_comb begin
    load_data = '0;
    case (pend_funct3_reg)
      3'b000:  load_data = DATA_WIDTH'($signed(byte_val));
      3'b100:  load_data = DATA_WIDTH'(byte_val);
      3'b001:  load_data = DATA_WIDTH'($signed(half_val));
      3'b101:  load_data = DATA_WIDTH'(half_val);
      3'b010:  load_data = DATA_WIDTH'($signed(word_val));
      3'b110:  if (DATA_WIDTH == 64) load_data = DATA_WIDTH'(word_val);
      3'b011:  if (DATA_WIDTH == 64) load_data = mem_rdata_i;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    pend_rd_next     = pend_rd_reg;
    pend_funct3_next = pend_funct3_reg;
    pend_lsb_next    = pend_lsb_reg;
    wb_valid_next    = 1'b0;
    rd_next          = rd_o;
    rd_data_next     = rd_data_o;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_load_i) begin
            pend_rd_next     = rd_i;
            pend_funct3_next = funct3_i;
            pend_lsb_next    = addr_lsb_i;
            state_next       = WAIT_MEM;
          end else begin
            wb_valid_next = 1'b1;
            rd_next       = rd_i;
            rd_data_next  = exe_data_i;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid_i) begin
          wb_valid_next = 1'b1;
          rd_next       = pend_rd_reg;
          rd_data_next  = load_data;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg       <= IDLE;
      pend_rd_reg     <= '0;
      pend_funct3_reg <= '0;
      pend_lsb_reg    <= '0;
      wb_valid_o      <= 1'b0;
      rd_o            <= '0;
      rd_data_o       <= '0;
    end else begin
      state_reg       <= state_next;
      pend_rd_reg     <= pend_rd_next;
      pend_funct3_reg <= pend_funct3_next;
      pend_lsb_reg    <= pend_lsb_next;
      wb_valid_o      <= wb_valid_next;
      rd_o            <= rd_next;
      rd_data_o       <= rd_data_next;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Counts registered write pulses, so it trails wb_valid_o by one cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      instret_o <= 64'd0;
    end else if (wb_valid_o) begin
      instret_o <= instret_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed scenarios with literal expectations, followed by a randomized run.
// A transaction-level model (busy flag plus pending-load record, load data
// computed with plain shifts and masks) predicts the outputs after every clock
// edge. A single negedge process compares the DUT against it.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [AW-1:0] rd_in = '0;
  logic [DW-1:0] exe_data = '0;
  logic          is_load = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [2:0]    addr_lsb = '0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          wb_valid;
  logic [AW-1:0] rd_out;
  logic [DW-1:0] rd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]   instret;
`endif

  always #5 clk = ~clk;

  writeback_stage #(.DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .valid_i      (valid),
    .ready_o      (ready),
    .rd_i         (rd_in),
    .exe_data_i   (exe_data),
    .is_load_i    (is_load),
    .funct3_i     (funct3),
    .addr_lsb_i   (addr_lsb),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .wb_valid_o   (wb_valid),
    .rd_o         (rd_out),
    .rd_data_o    (rd_data)
`ifdef WB_RETIRE_CNT_EN
    ,
    .instret_o    (instret)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  // Reference model state
  logic          m_busy = 1'b0;
  logic [AW-1:0] m_rd = '0;
  logic [2:0]    m_f3 = '0;
  logic [2:0]    m_lsb = '0;
  logic          exp_wb = 1'b0;
  logic [AW-1:0] exp_rd = '0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_inrst = 1'b1;
  longint unsigned m_cnt = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic longint unsigned sext(input longint unsigned x, input int n);
    if (((x >> (n - 1)) & 64'd1) != 0) return x | (~64'd0 << n);
    return x;
  endfunction

  function automatic logic [DW-1:0] ref_load(input logic [2:0] f3, input logic [2:0] lsb,
                                             input logic [DW-1:0] word);
    longint unsigned w, v;
    int off;
    w = 64'(word);
    off = (DW == 64) ? int'(lsb) : int'(lsb) % 4;
    v = 0;
    case (f3)
      3'd0: v = sext((w >> (8 * off)) & 64'hFF, 8);
      3'd4: v = (w >> (8 * off)) & 64'hFF;
      3'd1: v = sext((w >> (8 * ((off / 2) * 2))) & 64'hFFFF, 16);
      3'd5: v = (w >> (8 * ((off / 2) * 2))) & 64'hFFFF;
      3'd2: v = sext((w >> (8 * ((off / 4) * 4))) & 64'hFFFF_FFFF, 32);
      3'd6: if (DW == 64) v = (w >> (8 * ((off / 4) * 4))) & 64'hFFFF_FFFF;
      3'd3: if (DW == 64) v = w;
      default: v = 0;
    endcase
    return v[DW-1:0];
  endfunction

  task automatic model_reset();
    m_busy    = 1'b0;
    exp_wb    = 1'b0;
    exp_rd    = '0;
    exp_data  = '0;
    exp_inrst = 1'b1;
    m_cnt     = 0;
  endtask

  // Apply the effect of one clock edge using the inputs held across it.
  task automatic model_edge();
    if (!rstn) begin
      model_reset();
    end else begin
      exp_inrst = 1'b0;
      if (exp_wb) m_cnt++;
      if (!m_busy) begin
        exp_wb = 1'b0;
        if (valid) begin
          if (is_load) begin
            m_busy = 1'b1;
            m_rd   = rd_in;
            m_f3   = funct3;
            m_lsb  = addr_lsb;
          end else begin
            exp_wb   = 1'b1;
            exp_rd   = rd_in;
            exp_data = exe_data;
          end
        end
      end else if (mem_rvalid) begin
        m_busy   = 1'b0;
        exp_wb   = 1'b1;
        exp_rd   = m_rd;
        exp_data = ref_load(m_f3, m_lsb, mem_rdata);
      end else begin
        exp_wb = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Reset is asynchronous: asserting it clears the expectation at once.
  task automatic set_rst(input logic v);
    rstn = v;
    if (!v) model_reset();
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("ready", 64'(ready), 64'(!m_busy));
      cmp("wb_valid", 64'(wb_valid), 64'(exp_wb));
      if (exp_wb || exp_inrst) begin
        cmp("rd", 64'(rd_out), 64'(exp_rd));
        cmp("rd_data", 64'(rd_data), 64'(exp_data));
      end
      if (exp_wb) $display("WR rd=%0d data=%08h t=%0t", rd_out, rd_data, $time);
`ifdef WB_RETIRE_CNT_EN
      cmp("instret", instret, m_cnt);
`endif
    end
  end

  task automatic do_load(input logic [2:0] f3, input logic [2:0] lsb, input logic [DW-1:0] word,
                         input int delay, input logic [AW-1:0] rdv, input logic [DW-1:0] expv);
    valid = 1'b1; is_load = 1'b1; funct3 = f3; addr_lsb = lsb; rd_in = rdv; mem_rvalid = 1'b0;
    step();
    valid = 1'b0; is_load = 1'b0;
    cmp("ld_wait_ready", 64'(ready), 64'd0);
    cmp("ld_wait_wb", 64'(wb_valid), 64'd0);
    for (int i = 0; i < delay; i++) begin
      step();
      cmp("ld_wait_ready", 64'(ready), 64'd0);
      cmp("ld_wait_wb", 64'(wb_valid), 64'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = word;
    step();
    mem_rvalid = 1'b0;
    cmp("ld_wb", 64'(wb_valid), 64'd1);
    cmp("ld_rd", 64'(rd_out), 64'(rdv));
    cmp("ld_data", 64'(rd_data), 64'(expv));
    cmp("ld_ready_back", 64'(ready), 64'd1);
    step();
    cmp("ld_pulse_end", 64'(wb_valid), 64'd0);
  endtask

  initial begin
    // Reset state
    step();
    chk_on = 1'b1;
    step();
    cmp("rst_wb", 64'(wb_valid), 64'd0);
    cmp("rst_rd", 64'(rd_out), 64'd0);
    cmp("rst_data", 64'(rd_data), 64'd0);
    cmp("rst_ready", 64'(ready), 64'd1);
    set_rst(1'b1);
    step();

    // Three back-to-back ALU writes
    for (int i = 1; i <= 3; i++) begin
      valid = 1'b1; is_load = 1'b0; rd_in = AW'(i); exe_data = DW'(32'h11 * i);
      step();
      cmp("alu_wb", 64'(wb_valid), 64'd1);
      cmp("alu_rd", 64'(rd_out), 64'(i));
      cmp("alu_data", 64'(rd_data), 64'(32'h11 * i));
      cmp("alu_ready", 64'(ready), 64'd1);
    end
    valid = 1'b0;
    step();
    cmp("alu_idle_wb", 64'(wb_valid), 64'd0);

    // Load extraction cases
    do_load(3'b000, 3'd3, 32'h80FF_0000, 2, 5'd5, 32'hFFFF_FF80);
    do_load(3'b101, 3'd2, 32'h8001_1234, 0, 5'd6, 32'h0000_8001);
    do_load(3'b001, 3'd2, 32'h8001_1234, 1, 5'd0, 32'hFFFF_8001);
    do_load(3'b111, 3'd0, 32'hDEAD_BEEF, 0, 5'd4, 32'h0000_0000);

    // valid held high while waiting; queued ALU op accepted right after
    valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr_lsb = 3'd1; rd_in = 5'd8;
    step();
    is_load = 1'b0; rd_in = 5'd7; exe_data = 32'h0000_0ABC;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("hold_ready", 64'(ready), 64'd0);
      cmp("hold_wb", 64'(wb_valid), 64'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    cmp("hold_ld_rd", 64'(rd_out), 64'd8);
    cmp("hold_ld_data", 64'(rd_data), 64'h1234_5678);
    step();
    cmp("hold_alu_wb", 64'(wb_valid), 64'd1);
    cmp("hold_alu_rd", 64'(rd_out), 64'd7);
    cmp("hold_alu_data", 64'(rd_data), 64'h0ABC);
    valid = 1'b0;
    step();

    // Reset in the middle of a load, then a stray late response
    valid = 1'b1; is_load = 1'b1; funct3 = 3'b000; rd_in = 5'd9;
    step();
    valid = 1'b0; is_load = 1'b0;
    step();
    set_rst(1'b0);
    #1;
    cmp("midrst_wb", 64'(wb_valid), 64'd0);
    cmp("midrst_rd", 64'(rd_out), 64'd0);
    cmp("midrst_data", 64'(rd_data), 64'd0);
    cmp("midrst_ready", 64'(ready), 64'd1);
    step();
    set_rst(1'b1);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    cmp("late_rsp_wb", 64'(wb_valid), 64'd0);
    step();
    cmp("late_rsp_wb2", 64'(wb_valid), 64'd0);

`ifdef WB_RETIRE_CNT_EN
    // 4 ALU + 1 load after a fresh reset -> count of 5
    set_rst(1'b0);
    step();
    cmp("cnt_rst", instret, 64'd0);
    set_rst(1'b1);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; is_load = 1'b0; rd_in = AW'(i + 10); exe_data = DW'(i);
      step();
    end
    valid = 1'b0;
    do_load(3'b100, 3'd1, 32'h0000_AB00, 1, 5'd20, 32'h0000_00AB);
    cmp("cnt_five", instret, 64'd5);
`endif

    // Randomized run
    for (int c = 0; c < 3000; c++) begin
      set_rst(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
      valid      = $urandom_range(0, 1) == 1;
      is_load    = $urandom_range(0, 1) == 1;
      funct3     = 3'($urandom_range(0, 7));
      addr_lsb   = 3'($urandom_range(0, 7));
      rd_in      = AW'($urandom);
      exe_data   = DW'($urandom);
      mem_rvalid = $urandom_range(0, 2) == 0;
      mem_rdata  = DW'($urandom);
      step();
    end
    set_rst(1'b1);
    valid = 1'b0; mem_rvalid = 1'b0;
    step();
    step();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the SCHOLAR RISC-V core. It sits directly upstream of the general purpose register file.
- Accepts completed instructions from execute: ALU results, or load requests awaiting memory data.
- Waits for load responses, then extracts, aligns and sign/zero-extends the load data.
- Drives the register-file write port (wb_valid, rd, rd_data) as a registered, single-cycle write pulse.

Parameters:
- DATA_WIDTH, 32 (from core_pkg), datapath width; 32 or 64 only.
- RF_ADDR_WIDTH, 5 (from core_pkg), register index width.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- valid_i  in  1  execute stage presents an instruction
- ready_o  out  1  stage can accept an instruction this cycle
- rd_i  in  RF_ADDR_WIDTH  destination register
- exe_data_i  in  DATA_WIDTH  ALU/CSR result for non-load instructions
- is_load_i  in  1  instruction is a load
- funct3_i  in  3  load type (RISC-V funct3)
- addr_lsb_i  in  3  low bits of the load byte address
- mem_rvalid_i  in  1  data memory read response valid
- mem_rdata_i  in  DATA_WIDTH  data memory read word (naturally aligned word/dword)
- wb_valid_o  out  1  register-file write enable
- rd_o  out  RF_ADDR_WIDTH  register-file write address
- rd_data_o  out  DATA_WIDTH  register-file write data

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is rstn_i, asynchronous and active-low. While rstn_i is low:
  - state = IDLE;
  - wb_valid_o = 0, rd_o = 0, rd_data_o = 0;
  - ready_o = 1 (decoded from state);
  - any pending load is discarded with no write. This holds even when reset is asserted mid-load.
- States: IDLE and WAIT_MEM. ready_o = 1 in IDLE and 0 in WAIT_MEM (pure decode of the state).
- Accept condition: valid_i && ready_o.
- IDLE, accept with is_load_i = 0:
  - next cycle: wb_valid_o = 1, rd_o = rd_i, rd_data_o = exe_data_i;
  - 1-cycle latency; back-to-back throughput is 1 per cycle.
- IDLE, accept with is_load_i = 1:
  - latch rd_i, funct3_i and addr_lsb_i into pending registers;
  - go to WAIT_MEM;
  - wb_valid_o = 0 next cycle (unless it is driven by nothing else).
- mem_rvalid_i in IDLE: ignored. A load response never arrives in the same cycle the load is accepted.
- WAIT_MEM:
  - hold until mem_rvalid_i = 1; valid_i is ignored.
  - on mem_rvalid_i: the next cycle drives wb_valid_o = 1, rd_o = pending rd, rd_data_o = extracted data, and the state returns to IDLE.
  - load-to-write latency = response cycle + 1.
- wb_valid_o is a one-cycle pulse per retired instruction; it is 0 in every cycle without a retirement.
- rd = 0: the write is still issued (wb_valid_o = 1, rd_o = 0). Discarding x0 writes is the register file's job.
- Load extraction (offset = addr_lsb_i[1:0] for DATA_WIDTH 32, [2:0] for 64):
  - 000 LB: byte at offset, sign-extended;
  - 100 LBU: byte at offset, zero-extended;
  - 001 LH: halfword at offset rounded down to a multiple of 2, sign-extended;
  - 101 LHU: same halfword, zero-extended;
  - 010 LW: word at offset rounded down to a multiple of 4, sign-extended to DATA_WIDTH;
  - 110 LWU: 64 only; same word, zero-extended;
  - 011 LD: 64 only; full dword.
- Alignment: low alignment bits are ignored. Misaligned-access detection is upstream's responsibility.
- Illegal funct3 (111; 011/110 when DATA_WIDTH = 32): rd_data_o = 0 and the write is still issued.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - adds output port instret_o (out, 64), a retired-instruction counter;
  - reset value is 0;
  - increments by 1 in the cycle after each wb_valid_o = 1 (counts wb_valid_o pulses registered);
  - wraps from 2^64-1 to 0.
- When undefined: no port and no counter logic.

Test Plan:
- Reset, then 3 consecutive ALU instructions with rd = 1,2,3 and exe_data = 0x11,0x22,0x33 -> wb_valid_o high 3 consecutive cycles, one cycle after each accept, with matching rd/data; ready_o stays 1.
- LB, addr_lsb = 3, response 0x80FF_0000 -> ready_o = 0 until the response; next cycle rd_data_o = 0xFFFF_FF80, wb_valid_o for exactly 1 cycle.
- LHU, addr_lsb = 2, response 0x8001_1234 -> rd_data_o = 0x0000_8001. Repeat with LH -> 0xFFFF_8001.
- valid_i held high in WAIT_MEM with a response delayed 5 cycles -> no accept and no write until the response, then the queued instruction is accepted in the first IDLE cycle.
- rstn_i low during WAIT_MEM, then a late mem_rvalid_i -> no wb_valid_o pulse; outputs are 0 and ready_o = 1 immediately.
- With WB_RETIRE_CNT_EN: 4 ALU instructions plus 1 load -> instret_o = 5 after the last write; 0 after reset.
